// File: rtl/miriscv_data_arbiter.sv
// Two-requester arbiter for the single data-memory port.
// Requester 0 is the core LSU, requester 1 a secondary master (DMA/debug).
// Round-robin grant, one outstanding transaction, timeout termination.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   mX_req_i/we/be/addr/wdata requester X request and its fields
//   mX_gnt_o                  requester X accepted (combinational 1-cycle pulse)
//   mX_rvalid_o/rdata/err     requester X response (registered); err marks a timeout
//   data_req_o/we/be/addr/wdata  memory request side, driven from latched fields
//   data_gnt_i, data_rvalid_i, data_rdata_i  memory handshake and response
module miriscv_data_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam int unsigned CntW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e          state_q;
    logic            last_grant_q;
    logic            winner_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      rvalid_q;
    logic [1:0]      err_q;
    logic [31:0]     rdata_q [2];

    logic win_id;
    logic grant;
    logic timeout_hit;

    // Contested request goes to whoever was not served last.
    always_comb begin
        if (m0_req_i && m1_req_i) begin
            win_id = ~last_grant_q;
        end else begin
            win_id = m1_req_i;
        end
    end

    // A grant during reset would be discarded by the reset, so suppress it.
    assign grant       = (state_q == StIdle) && (m0_req_i || m1_req_i) && !rst_i;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES));

    assign m0_gnt_o     = grant && !win_id;
    assign m1_gnt_o     = grant && win_id;
    assign data_req_o   = (state_q == StIssue);
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;
    assign m0_rvalid_o  = rvalid_q[0];
    assign m1_rvalid_o  = rvalid_q[1];
    assign m0_err_o     = err_q[0];
    assign m1_err_o     = err_q[1];
    assign m0_rdata_o   = rdata_q[0];
    assign m1_rdata_o   = rdata_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rvalid_q     <= '0;
            err_q        <= '0;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
        end else begin
            rvalid_q <= '0;
            err_q    <= '0;
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        winner_q     <= win_id;
                        last_grant_q <= win_id;
                        we_q         <= win_id ? m1_we_i    : m0_we_i;
                        be_q         <= win_id ? m1_be_i    : m0_be_i;
                        addr_q       <= win_id ? m1_addr_i  : m0_addr_i;
                        wdata_q      <= win_id ? m1_wdata_i : m0_wdata_i;
                        cnt_q        <= '0;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q <= cnt_q + CntW'(1);
                    // Timeout takes priority over a same-cycle memory grant.
                    if (timeout_hit) begin
                        rvalid_q[winner_q] <= 1'b1;
                        err_q[winner_q]    <= 1'b1;
                        rdata_q[winner_q]  <= TIMEOUT_RDATA;
                        state_q            <= StIdle;
                    end else if (data_gnt_i) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + CntW'(1);
                    // A response arriving in the timeout cycle still wins.
                    if (data_rvalid_i) begin
                        rvalid_q[winner_q] <= 1'b1;
                        rdata_q[winner_q]  <= data_rdata_i;
                        state_q            <= StIdle;
                    end else if (timeout_hit) begin
                        rvalid_q[winner_q] <= 1'b1;
                        err_q[winner_q]    <= 1'b1;
                        rdata_q[winner_q]  <= TIMEOUT_RDATA;
                        state_q            <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
module tb_miriscv_data_arbiter;

    localparam int unsigned TO       = 8;
    localparam logic [31:0] TO_RDATA = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;

    int total = 0;
    int bad   = 0;

    miriscv_data_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_RDATA (TO_RDATA)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .m0_req_i     (m0_req),
        .m0_we_i      (m0_we),
        .m0_be_i      (m0_be),
        .m0_addr_i    (m0_addr),
        .m0_wdata_i   (m0_wdata),
        .m0_gnt_o     (m0_gnt),
        .m0_rvalid_o  (m0_rvalid),
        .m0_rdata_o   (m0_rdata),
        .m0_err_o     (m0_err),
        .m1_req_i     (m1_req),
        .m1_we_i      (m1_we),
        .m1_be_i      (m1_be),
        .m1_addr_i    (m1_addr),
        .m1_wdata_i   (m1_wdata),
        .m1_gnt_o     (m1_gnt),
        .m1_rvalid_o  (m1_rvalid),
        .m1_rdata_o   (m1_rdata),
        .m1_err_o     (m1_err),
        .data_req_o   (data_req),
        .data_we_o    (data_we),
        .data_be_o    (data_be),
        .data_addr_o  (data_addr),
        .data_wdata_o (data_wdata),
        .data_gnt_i   (data_gnt),
        .data_rvalid_i(data_rvalid),
        .data_rdata_i (data_rdata)
    );

    wire [139:0] all_out = {m0_gnt, m0_rvalid, m0_err, m0_rdata,
                            m1_gnt, m1_rvalid, m1_err, m1_rdata,
                            data_req, data_we, data_be, data_addr, data_wdata};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
        data_gnt = 0; data_rvalid = 0; data_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        m0_req = 1; m1_req = 1;
        next_cycle();
        #2;
        total++;
        if (all_out !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        next_cycle();
        rst = 0;
        m0_req = 0; m1_req = 0;
        #2;
        total++;
        if (all_out !== '0) begin
            bad++; $display("FAIL post_reset_idle: got %h want 0", all_out);
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req = 1; m0_we = 0; m0_be = 4'hF; m0_addr = 32'h100;
        #2;
        total++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            bad++; $display("FAIL read_gnt: got %b want 01", {m1_gnt, m0_gnt});
        end
        next_cycle();
        m0_req = 0; m0_addr = 32'h5555_0000; data_gnt = 1;
        #2;
        total++;
        if ({data_req, data_we, data_addr} !== {1'b1, 1'b0, 32'h100}) begin
            bad++; $display("FAIL read_issue: got req=%b we=%b addr=%h want 1 0 100",
                            data_req, data_we, data_addr);
        end
        next_cycle();
        data_gnt = 0; data_rvalid = 1; data_rdata = 32'hCAFE_F00D;
        #2;
        total++;
        if ({data_req, m0_rvalid} !== 2'b00) begin
            bad++; $display("FAIL read_wait: got req=%b rvalid=%b want 0 0", data_req, m0_rvalid);
        end
        next_cycle();
        data_rvalid = 0; data_rdata = '0;
        #2;
        total++;
        if ({m0_rvalid, m0_err, m0_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
            bad++; $display("FAIL read_resp: got rv=%b err=%b rdata=%h want 1 0 cafef00d",
                            m0_rvalid, m0_err, m0_rdata);
        end
        total++;
        if ({m1_gnt, m1_rvalid, m1_err, m1_rdata} !== '0) begin
            bad++; $display("FAIL read_m1_quiet: got %h want 0",
                            {m1_gnt, m1_rvalid, m1_err, m1_rdata});
        end
        next_cycle();
        #2;
        total++;
        if ({m0_rvalid, m0_rdata} !== {1'b0, 32'hCAFE_F00D}) begin
            bad++; $display("FAIL read_hold: got rv=%b rdata=%h want 0 cafef00d",
                            m0_rvalid, m0_rdata);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_oh;
        logic [1:0]  prev_oh;
        logic [31:0] got;
        do_reset();
        m0_req = 1; m0_addr = 32'h1000; m1_req = 1; m1_addr = 32'h2000; data_gnt = 1;
        prev_oh = 2'b00;
        for (int t = 0; t < 4; t++) begin
            exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
            data_rvalid = 0;
            #2;
            total++;
            if ({m1_gnt, m0_gnt} !== exp_oh) begin
                bad++; $display("FAIL rr_gnt%0d: got %b want %b", t, {m1_gnt, m0_gnt}, exp_oh);
            end
            total++;
            if ({m1_rvalid, m0_rvalid} !== prev_oh) begin
                bad++; $display("FAIL rr_rvalid%0d: got %b want %b", t,
                                {m1_rvalid, m0_rvalid}, prev_oh);
            end
            if (t > 0) begin
                got = prev_oh[1] ? m1_rdata : m0_rdata;
                total++;
                if (got !== 32'hA000_0000 + 32'(t - 1)) begin
                    bad++; $display("FAIL rr_rdata%0d: got %h want %h", t, got,
                                    32'hA000_0000 + 32'(t - 1));
                end
            end
            next_cycle();
            #2;
            total++;
            if (data_addr !== (exp_oh[1] ? 32'h2000 : 32'h1000)) begin
                bad++; $display("FAIL rr_addr%0d: got %h want %h", t, data_addr,
                                exp_oh[1] ? 32'h2000 : 32'h1000);
            end
            next_cycle();
            data_rvalid = 1; data_rdata = 32'hA000_0000 + 32'(t);
            next_cycle();
            prev_oh = exp_oh;
        end
        data_rvalid = 0; m0_req = 0; m1_req = 0;
        #2;
        total++;
        if ({m1_rvalid, m0_rvalid, m1_rdata, m0_rdata} !==
            {2'b10, 32'hA000_0003, 32'hA000_0002}) begin
            bad++; $display("FAIL rr_last: got rv=%b r1=%h r0=%h want 10 a0000003 a0000002",
                            {m1_rvalid, m0_rvalid}, m1_rdata, m0_rdata);
        end
        next_cycle();
    endtask

    task automatic test_write();
        do_reset();
        m1_req = 1; m1_we = 1; m1_be = 4'b0011; m1_addr = 32'h20; m1_wdata = 32'h1234_5678;
        #2;
        total++;
        if ({m1_gnt, m0_gnt} !== 2'b10) begin
            bad++; $display("FAIL wr_gnt: got %b want 10", {m1_gnt, m0_gnt});
        end
        next_cycle();
        m1_req = 0; m1_we = 0; m1_be = 4'hF; m1_addr = 32'hFFFF; m1_wdata = '0; data_gnt = 1;
        #2;
        total++;
        if ({data_req, data_we, data_be, data_addr, data_wdata} !==
            {2'b11, 4'b0011, 32'h20, 32'h1234_5678}) begin
            bad++; $display("FAIL wr_fields: got req=%b we=%b be=%b addr=%h wd=%h",
                            data_req, data_we, data_be, data_addr, data_wdata);
        end
        next_cycle();
        data_gnt = 0; data_rvalid = 1;
        next_cycle();
        data_rvalid = 0;
        #2;
        total++;
        if ({m1_rvalid, m1_err, m0_rvalid} !== 3'b100) begin
            bad++; $display("FAIL wr_ack: got m1rv=%b m1err=%b m0rv=%b want 1 0 0",
                            m1_rvalid, m1_err, m0_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_stall();
        do_reset();
        m0_req = 1; m0_we = 1; m0_be = 4'b0101; m0_addr = 32'h44; m0_wdata = 32'h0BAD_CAFE;
        next_cycle();
        m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = 32'h1; m0_wdata = 32'h2;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++;
            if ({data_req, data_we, data_be, data_addr, data_wdata} !==
                {2'b11, 4'b0101, 32'h44, 32'h0BAD_CAFE}) begin
                bad++; $display("FAIL stall%0d: got req=%b we=%b be=%b addr=%h wd=%h", i,
                                data_req, data_we, data_be, data_addr, data_wdata);
            end
            next_cycle();
        end
        data_gnt = 1;
        next_cycle();
        data_gnt = 0;
        #2;
        total++;
        if (data_req !== 1'b0) begin
            bad++; $display("FAIL stall_wait: got req=%b want 0", data_req);
        end
        data_rvalid = 1;
        next_cycle();
        data_rvalid = 0;
        #2;
        total++;
        if ({m0_rvalid, m0_err} !== 2'b10) begin
            bad++; $display("FAIL stall_resp: got rv=%b err=%b want 1 0", m0_rvalid, m0_err);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        m0_req = 1; m0_addr = 32'h300;
        next_cycle();
        m0_req = 0;
        // k counts cycles after the grant; the request is issued at k=1.
        for (int k = 1; k <= 14; k++) begin
            data_gnt    = (k == 1);
            data_rvalid = (k == 11 || k == 12);
            #2;
            total++;
            if ({m0_rvalid, m0_err} !== {2{k == int'(TO) + 2}}) begin
                bad++; $display("FAIL to_rv%0d: got rv=%b err=%b want %b", k, m0_rvalid,
                                m0_err, k == int'(TO) + 2);
            end
            if (k == int'(TO) + 2) begin
                total++;
                if (m0_rdata !== TO_RDATA) begin
                    bad++; $display("FAIL to_rdata: got %h want %h", m0_rdata, TO_RDATA);
                end
            end
            next_cycle();
        end
        data_gnt = 0; data_rvalid = 0;
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        m0_req = 1; m0_addr = 32'h500;
        next_cycle();
        m0_req = 0; data_gnt = 1;
        next_cycle();
        data_gnt = 0; rst = 1;
        next_cycle();
        rst = 0; data_rvalid = 1; data_rdata = 32'h7777_7777;
        #2;
        total++;
        if (all_out !== '0) begin
            bad++; $display("FAIL rstw_outputs: got %h want 0", all_out);
        end
        next_cycle();
        data_rvalid = 0;
        m0_req = 1; m1_req = 1;
        #2;
        total++;
        if ({m1_rvalid, m0_rvalid, m0_rdata} !== '0) begin
            bad++; $display("FAIL rstw_no_resp: got rv=%b rdata=%h want 0",
                            {m1_rvalid, m0_rvalid}, m0_rdata);
        end
        total++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            bad++; $display("FAIL rstw_gnt: got %b want 01", {m1_gnt, m0_gnt});
        end
        next_cycle();
        clear_inputs();
    endtask

    // Transaction-level reference: one open transaction with an absolute deadline.
    task automatic test_random();
        bit          busy, who, acc, last, hang, resp, resp_who, resp_err, w;
        int          deadline;
        logic        t_we;
        logic [3:0]  t_be;
        logic [31:0] t_addr, t_wdata;
        logic [31:0] hold [2];
        logic [1:0]  exp_gnt, exp_rv, exp_err;
        do_reset();
        busy = 0; who = 0; acc = 0; last = 1; hang = 0; resp = 0; resp_who = 0;
        resp_err = 0; w = 0; deadline = 0;
        t_we = 0; t_be = '0; t_addr = '0; t_wdata = '0;
        hold[0] = '0; hold[1] = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            m0_req = ($urandom_range(0, 3) != 0); m0_we = ($urandom_range(0, 1) == 1);
            m0_be = 4'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
            m1_req = ($urandom_range(0, 3) != 0); m1_we = ($urandom_range(0, 1) == 1);
            m1_be = 4'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
            data_gnt = ($urandom_range(0, 2) == 0);
            if (busy && acc && !hang) data_rvalid = ($urandom_range(0, 3) == 0);
            else                      data_rvalid = ($urandom_range(0, 9) == 0);
            data_rdata = $urandom;

            exp_gnt = 2'b00;
            if (!busy && (m0_req || m1_req)) begin
                w = (m0_req && m1_req) ? !last : m1_req;
                exp_gnt[w] = 1'b1;
            end
            exp_rv  = resp ? (2'b01 << resp_who) : 2'b00;
            exp_err = (resp && resp_err) ? (2'b01 << resp_who) : 2'b00;

            #2;
            total++;
            if ({m1_gnt, m0_gnt} !== exp_gnt) begin
                bad++; $display("FAIL rnd_gnt@%0d: got %b want %b", cyc, {m1_gnt, m0_gnt},
                                exp_gnt);
            end
            total++;
            if (data_req !== (busy && !acc)) begin
                bad++; $display("FAIL rnd_req@%0d: got %b want %b", cyc, data_req,
                                busy && !acc);
            end
            if (busy) begin
                total++;
                if ({data_we, data_be, data_addr, data_wdata} !== {t_we, t_be, t_addr, t_wdata})
                begin
                    bad++; $display("FAIL rnd_fields@%0d: got %h want %h", cyc,
                                    {data_we, data_be, data_addr, data_wdata},
                                    {t_we, t_be, t_addr, t_wdata});
                end
            end
            total++;
            if ({m1_rvalid, m0_rvalid, m1_err, m0_err} !== {exp_rv, exp_err}) begin
                bad++; $display("FAIL rnd_resp@%0d: got rv=%b err=%b want rv=%b err=%b", cyc,
                                {m1_rvalid, m0_rvalid}, {m1_err, m0_err}, exp_rv, exp_err);
            end
            total++;
            if ({m1_rdata, m0_rdata} !== {hold[1], hold[0]}) begin
                bad++; $display("FAIL rnd_rdata@%0d: got %h %h want %h %h", cyc, m1_rdata,
                                m0_rdata, hold[1], hold[0]);
            end

            resp = 0;
            if (busy) begin
                if (acc && data_rvalid) begin
                    resp = 1; resp_who = who; resp_err = 0; hold[who] = data_rdata; busy = 0;
                end else if (cyc == deadline) begin
                    resp = 1; resp_who = who; resp_err = 1; hold[who] = TO_RDATA; busy = 0;
                end else if (!acc && data_gnt) begin
                    acc = 1;
                end
            end else if (exp_gnt != 2'b00) begin
                busy = 1; who = w; acc = 0; last = w;
                deadline = cyc + 1 + int'(TO);
                hang = ($urandom_range(0, 9) == 0);
                if (w) {t_we, t_be, t_addr, t_wdata} = {m1_we, m1_be, m1_addr, m1_wdata};
                else   {t_we, t_be, t_addr, t_wdata} = {m0_we, m0_be, m0_addr, m0_wdata};
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_stall();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
